vdma_frame_buf_sched: RTL and testbench

//  Triple-buffer frame scheduler for the VDMA write/read paths. Rotates three DDR frame slots so the
//  8-bit video input writer and the display reader never touch the same slot. Drives the writer's
//  per-frame base address (sampled by the input block while vsync is high) and hands completed frames to the reader.

---
 rtl/vdma_frame_buf_sched.sv | 145 ++++++++++++++
 tb/tb_vdma_frame_buf_sched.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/vdma_frame_buf_sched.sv
// Triple-buffer frame scheduler for the VDMA write/read paths.
// Three DDR frame slots rotate between the writer, the reader and one
// "ready" slot holding the newest completed frame.  The writer never
// picks the reader's slot or the ready slot, so the two paths never collide.
module vdma_frame_buf_sched #(
    parameter int                   ADDR_BITS    = 25,
    parameter logic [ADDR_BITS-1:0] BASE_ADDR    = '0,
    parameter logic [ADDR_BITS-1:0] FRAME_STRIDE = 25'h100000
) (
    input  logic                 pclk,
    input  logic                 prst,
    input  logic                 en,
    input  logic                 wr_vsync,
    input  logic                 wr_frame_done,
    input  logic                 rd_req,
    output logic [ADDR_BITS-1:0] wr_baseaddr,
    output logic                 wr_busy,
    output logic [ADDR_BITS-1:0] rd_baseaddr,
    output logic                 rd_ack,
    output logic                 rd_new,
    output logic [15:0]          drop_cnt,
    output logic [15:0]          abort_cnt
);

    typedef enum logic {W_IDLE, W_ACTIVE} wstate_t;

    // Slot ownership: writer, reader, and the newest completed frame.
    typedef struct packed {
        logic [1:0] wr_idx;
        logic [1:0] rd_idx;
        logic [1:0] rdy_idx;
        logic       rdy_valid;
    } slots_t;

    localparam slots_t SLOTS_RST = '{wr_idx: 2'd1, rd_idx: 2'd0, rdy_idx: 2'd2, rdy_valid: 1'b0};

    function automatic logic [1:0] mod3_add(input logic [1:0] i, input logic [1:0] k);
        logic [2:0] s;
        s = {1'b0, i} + {1'b0, k};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    function automatic logic [ADDR_BITS-1:0] slot_addr(input logic [1:0] i);
        return BASE_ADDR + ADDR_BITS'(i) * FRAME_STRIDE;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    wstate_t     state, state_nxt;
    slots_t      sl, sl_nxt;
    logic        vsync_q, wr_start;
    logic [15:0] drop_nxt, abort_nxt;
    logic        ack_nxt, new_nxt;
    logic [1:0]  cand1, cand2;

    // Registered vsync rising edge, gated by enable: the per-frame start strobe.
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            vsync_q  <= 1'b0;
            wr_start <= 1'b0;
        end else begin
            vsync_q  <= wr_vsync;
            wr_start <= wr_vsync & ~vsync_q & en;
        end
    end

    // Scheduler state and counter registers.
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            state     <= W_IDLE;
            sl        <= SLOTS_RST;
            drop_cnt  <= '0;
            abort_cnt <= '0;
        end else begin
            state     <= state_nxt;
            sl        <= sl_nxt;
            drop_cnt  <= drop_nxt;
            abort_cnt <= abort_nxt;
        end
    end

    // Next state: completion first, then the reader, then the writer's new
    // slot chosen against the already-updated reader/ready ownership.
    always_comb begin
        state_nxt = state;
        sl_nxt    = sl;
        drop_nxt  = drop_cnt;
        abort_nxt = abort_cnt;
        ack_nxt   = 1'b0;
        new_nxt   = 1'b0;
        cand1     = mod3_add(sl.wr_idx, 2'd1);
        cand2     = mod3_add(sl.wr_idx, 2'd2);

        if (state == W_ACTIVE && wr_frame_done) begin
            if (sl.rdy_valid)
                drop_nxt = sat_inc(drop_cnt);
            sl_nxt.rdy_idx   = sl.wr_idx;
            sl_nxt.rdy_valid = 1'b1;
            state_nxt        = W_IDLE;
        end

        if (rd_req) begin
            ack_nxt = 1'b1;
            if (sl_nxt.rdy_valid) begin
                sl_nxt.rd_idx    = sl_nxt.rdy_idx;
                sl_nxt.rdy_valid = 1'b0;
                new_nxt          = 1'b1;
            end
        end

        if (wr_start) begin
            if (state_nxt == W_ACTIVE) begin
                // Restart without completion: keep the slot, count the abort.
                abort_nxt = sat_inc(abort_cnt);
            end else begin
                state_nxt = W_ACTIVE;
                if (cand1 != sl_nxt.rd_idx && !(sl_nxt.rdy_valid && cand1 == sl_nxt.rdy_idx))
                    sl_nxt.wr_idx = cand1;
                else
                    sl_nxt.wr_idx = cand2;
            end
        end
    end

    // Output registers; the read address tracks the new reader slot so it
    // lands together with rd_ack.
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            wr_baseaddr <= slot_addr(SLOTS_RST.wr_idx);
            rd_baseaddr <= slot_addr(SLOTS_RST.rd_idx);
            rd_ack      <= 1'b0;
            rd_new      <= 1'b0;
        end else begin
            wr_baseaddr <= slot_addr(sl.wr_idx);
            rd_baseaddr <= slot_addr(sl_nxt.rd_idx);
            rd_ack      <= ack_nxt;
            rd_new      <= new_nxt;
        end
    end

    assign wr_busy = (state == W_ACTIVE);

endmodule

// File: tb/tb_vdma_frame_buf_sched.sv
// Bench for vdma_frame_buf_sched: directed per-cycle vector table, explicit
// reset sequences, then randomized traffic against a slot-ownership model.
module tb_vdma_frame_buf_sched;

    localparam logic [24:0] S0 = 25'h000000;
    localparam logic [24:0] S1 = 25'h100000;
    localparam logic [24:0] S2 = 25'h200000;

    logic        pclk, prst, en, wr_vsync, wr_frame_done, rd_req;
    logic [24:0] wr_baseaddr, rd_baseaddr;
    logic        wr_busy, rd_ack, rd_new;
    logic [15:0] drop_cnt, abort_cnt;

    vdma_frame_buf_sched #(
        .ADDR_BITS(25), .BASE_ADDR(25'h0), .FRAME_STRIDE(25'h100000)
    ) dut (
        .pclk(pclk), .prst(prst), .en(en), .wr_vsync(wr_vsync),
        .wr_frame_done(wr_frame_done), .rd_req(rd_req),
        .wr_baseaddr(wr_baseaddr), .wr_busy(wr_busy), .rd_baseaddr(rd_baseaddr),
        .rd_ack(rd_ack), .rd_new(rd_new), .drop_cnt(drop_cnt), .abort_cnt(abort_cnt)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frames are owned by three roles; the newest completed
    // frame sits in a one-deep queue until read or superseded.
    int          m_wr, m_rd;
    int          m_rdy[$];
    bit          m_act, m_vq, m_start;
    int          m_drop, m_abort;
    logic [24:0] e_wa, e_ra;
    bit          e_ack, e_new;

    function automatic logic [24:0] addr(input int i);
        return 25'(i * 32'h100000);
    endfunction

    task automatic model_reset();
        m_wr = 1; m_rd = 0; m_rdy.delete();
        m_act = 0; m_vq = 0; m_start = 0;
        m_drop = 0; m_abort = 0;
        e_wa = addr(1); e_ra = addr(0); e_ack = 0; e_new = 0;
    endtask

    function automatic bit slot_free(input int c);
        if (c == m_rd) return 0;
        if (m_rdy.size() != 0 && m_rdy[0] == c) return 0;
        return 1;
    endfunction

    task automatic model_step(input bit ien, input bit vs, input bit dn, input bit rq);
        bit start;
        int pick;
        start   = m_start;
        m_start = vs && !m_vq && ien;
        m_vq    = vs;
        e_wa    = addr(m_wr);
        if (m_act && dn) begin
            if (m_rdy.size() != 0) begin
                if (m_drop < 65535) m_drop++;
                m_rdy.delete();
            end
            m_rdy.push_back(m_wr);
            m_act = 0;
        end
        e_ack = rq;
        e_new = 0;
        if (rq && m_rdy.size() != 0) begin
            m_rd  = m_rdy.pop_front();
            e_new = 1;
        end
        e_ra = addr(m_rd);
        if (start) begin
            if (m_act) begin
                if (m_abort < 65535) m_abort++;
            end else begin
                pick = -1;
                for (int k = 1; k <= 2; k++)
                    if (pick < 0 && slot_free((m_wr + k) % 3)) pick = (m_wr + k) % 3;
                m_wr  = pick;
                m_act = 1;
            end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".busy"},  32'(wr_busy),     32'(m_act));
        check({tag, ".waddr"}, 32'(wr_baseaddr), 32'(e_wa));
        check({tag, ".raddr"}, 32'(rd_baseaddr), 32'(e_ra));
        check({tag, ".ack"},   32'(rd_ack),      32'(e_ack));
        check({tag, ".new"},   32'(rd_new),      32'(e_new));
        check({tag, ".drop"},  32'(drop_cnt),    32'(m_drop));
        check({tag, ".abort"}, 32'(abort_cnt),   32'(m_abort));
    endtask

    // Drive one cycle at the falling edge, sample at the next falling edge.
    task automatic cycle(input bit ien, input bit vs, input bit dn, input bit rq);
        en = ien; wr_vsync = vs; wr_frame_done = dn; rd_req = rq;
        model_step(ien, vs, dn, rq);
        @(negedge pclk);
        check_model("model");
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".busy"},  32'(wr_busy),     32'd0);
        check({tag, ".waddr"}, 32'(wr_baseaddr), 32'(S1));
        check({tag, ".raddr"}, 32'(rd_baseaddr), 32'(S0));
        check({tag, ".ack"},   32'(rd_ack),      32'd0);
        check({tag, ".new"},   32'(rd_new),      32'd0);
        check({tag, ".drop"},  32'(drop_cnt),    32'd0);
        check({tag, ".abort"}, 32'(abort_cnt),   32'd0);
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic mid_reset(input string tag);
        #2 prst = 1'b1;
        #1;
        model_reset();
        check_reset_vals(tag);
        @(negedge pclk);
        prst = 1'b0;
    endtask

    typedef struct {
        bit          en, vs, dn, rq;
        bit          busy;
        logic [24:0] wa, ra;
        bit          ack, nw;
        int          drop, abort;
    } vec_t;

    function automatic vec_t mk(input bit ien, vs, dn, rq, bz, input logic [24:0] wa, ra,
                                input bit ak, nw, input int dr, ab);
        vec_t v;
        v.en = ien; v.vs = vs; v.dn = dn; v.rq = rq; v.busy = bz;
        v.wa = wa; v.ra = ra; v.ack = ak; v.nw = nw; v.drop = dr; v.abort = ab;
        return v;
    endfunction

    vec_t tbl[34];

    initial begin
        //            en vs dn rq | busy wa  ra  ack new drop abort
        tbl[0]  = mk(1, 1, 0, 0,   0, S1, S0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 1, 0, 0,   1, S1, S0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 0, 0, 0,   1, S2, S0, 0, 0, 0, 0);  // slot 2 two cycles after rise
        tbl[3]  = mk(1, 0, 1, 0,   0, S2, S0, 0, 0, 0, 0);
        tbl[4]  = mk(1, 0, 0, 1,   0, S2, S2, 1, 1, 0, 0);  // fresh frame handed to reader
        tbl[5]  = mk(1, 0, 0, 0,   0, S2, S2, 0, 0, 0, 0);
        tbl[6]  = mk(1, 1, 0, 0,   0, S2, S2, 0, 0, 0, 0);
        tbl[7]  = mk(1, 0, 0, 0,   1, S2, S2, 0, 0, 0, 0);
        tbl[8]  = mk(1, 0, 0, 0,   1, S0, S2, 0, 0, 0, 0);  // writer moves to slot 0
        tbl[9]  = mk(1, 0, 1, 0,   0, S0, S2, 0, 0, 0, 0);
        tbl[10] = mk(1, 1, 0, 0,   0, S0, S2, 0, 0, 0, 0);
        tbl[11] = mk(1, 0, 0, 0,   1, S0, S2, 0, 0, 0, 0);
        tbl[12] = mk(1, 0, 0, 0,   1, S1, S2, 0, 0, 0, 0);
        tbl[13] = mk(1, 0, 1, 0,   0, S1, S2, 0, 0, 1, 0);  // unread frame overwritten
        tbl[14] = mk(1, 0, 0, 1,   0, S1, S1, 1, 1, 1, 0);  // reader gets the second frame
        tbl[15] = mk(1, 0, 0, 1,   0, S1, S1, 1, 0, 1, 0);  // nothing ready: repeat
        tbl[16] = mk(1, 1, 0, 0,   0, S1, S1, 0, 0, 1, 0);
        tbl[17] = mk(1, 0, 0, 0,   1, S1, S1, 0, 0, 1, 0);
        tbl[18] = mk(1, 0, 0, 0,   1, S2, S1, 0, 0, 1, 0);
        tbl[19] = mk(1, 1, 0, 0,   1, S2, S1, 0, 0, 1, 0);
        tbl[20] = mk(1, 0, 0, 0,   1, S2, S1, 0, 0, 1, 1);  // restart without done
        tbl[21] = mk(1, 0, 0, 0,   1, S2, S1, 0, 0, 1, 1);
        tbl[22] = mk(1, 0, 1, 1,   0, S2, S2, 1, 1, 1, 1);  // done + req same cycle
        tbl[23] = mk(1, 0, 0, 1,   0, S2, S2, 1, 0, 1, 1);
        tbl[24] = mk(0, 1, 0, 0,   0, S2, S2, 0, 0, 1, 1);  // disabled: vsync ignored
        tbl[25] = mk(0, 0, 0, 0,   0, S2, S2, 0, 0, 1, 1);
        tbl[26] = mk(0, 0, 0, 0,   0, S2, S2, 0, 0, 1, 1);
        tbl[27] = mk(0, 0, 1, 0,   0, S2, S2, 0, 0, 1, 1);  // done while idle ignored
        tbl[28] = mk(0, 0, 0, 1,   0, S2, S2, 1, 0, 1, 1);
        tbl[29] = mk(1, 1, 0, 0,   0, S2, S2, 0, 0, 1, 1);
        tbl[30] = mk(1, 0, 0, 0,   1, S2, S2, 0, 0, 1, 1);
        tbl[31] = mk(1, 1, 0, 0,   1, S0, S2, 0, 0, 1, 1);
        tbl[32] = mk(1, 0, 1, 0,   1, S0, S2, 0, 0, 1, 1);  // done + start same cycle
        tbl[33] = mk(1, 0, 0, 0,   1, S1, S2, 0, 0, 1, 1);

        prst = 1'b1; en = 1'b0; wr_vsync = 1'b0; wr_frame_done = 1'b0; rd_req = 1'b0;
        model_reset();
        repeat (2) @(negedge pclk);
        check_reset_vals("reset");
        prst = 1'b0;

        for (int i = 0; i < 34; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            cycle(tbl[i].en, tbl[i].vs, tbl[i].dn, tbl[i].rq);
            check({tag, ".busy"},  32'(wr_busy),     32'(tbl[i].busy));
            check({tag, ".waddr"}, 32'(wr_baseaddr), 32'(tbl[i].wa));
            check({tag, ".raddr"}, 32'(rd_baseaddr), 32'(tbl[i].ra));
            check({tag, ".ack"},   32'(rd_ack),      32'(tbl[i].ack));
            check({tag, ".new"},   32'(rd_new),      32'(tbl[i].nw));
            check({tag, ".drop"},  32'(drop_cnt),    32'(tbl[i].drop));
            check({tag, ".abort"}, 32'(abort_cnt),   32'(tbl[i].abort));
        end

        // Writer is busy here: reset must clear everything without a clock.
        mid_reset("midrst");
        cycle(1, 1, 0, 0);
        cycle(1, 0, 0, 0);
        check("post_rst.busy", 32'(wr_busy), 32'd1);
        cycle(1, 0, 0, 0);
        check("post_rst.waddr", 32'(wr_baseaddr), 32'(S2));

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0)
                mid_reset("rndrst");
            cycle($urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
